// File: rtl/centroid_pkg.sv
// Shared FSM state type and width helpers for the multi-band centroid tracker.
package centroid_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, PUBLISH} state_t;

  function automatic int calc_xw(input int img_w);
    return $clog2(img_w);
  endfunction

  function automatic int calc_cw(input int roi_height, input int img_w);
    return $clog2(roi_height * img_w + 1);
  endfunction

  function automatic int calc_sw(input int roi_height, input int img_w);
    return calc_xw(img_w) + calc_cw(roi_height, img_w);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, QW quotient bits: start cycle loads, QW iterations, then a one-cycle done.
// The quotient must fit in QW bits; abort drops any divide in flight.
module seq_divider #(
  parameter int NW = 16,
  parameter int DW = 8,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CNTW = $clog2(QW + 1);

  logic [NW-1:0]   rem;
  logic [NW-1:0]   den;
  logic [QW-1:0]   q;
  logic [CNTW-1:0] cnt;
  logic            run;
  logic            done_q;
  logic            ge;

  assign ge       = (rem >= den);
  assign done     = done_q;
  assign quotient = q;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      rem    <= '0;
      den    <= '0;
      q      <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      // Divisor starts aligned to the top quotient bit and walks down one bit per cycle
      rem    <= dividend;
      den    <= NW'(divisor) << (QW - 1);
      q      <= '0;
      cnt    <= CNTW'(QW);
      run    <= 1'b1;
      done_q <= 1'b0;
    end else if (run) begin
      if (ge) rem <= rem - den;
      q   <= (q << 1) | QW'(ge);
      den <= den >> 1;
      cnt <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) begin
        run    <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_roi_centroid.sv
// Per-band edge centroids over stacked horizontal bands of a raster frame, plus heading
// and line-lost tracking; one shared divider resolves each band as it closes.
module multi_roi_centroid
  import centroid_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PIX_W       = 4,
  parameter int N_ROI       = 4,
  parameter int ROI_HEIGHT  = 32,
  parameter int THRESHOLD   = 2,
  parameter int MIN_COUNT   = 8,
  parameter int LOST_FRAMES = 3,
  localparam int XW = calc_xw(IMG_W),
  localparam int CW = calc_cw(ROI_HEIGHT, IMG_W),
  localparam int SW = calc_sw(ROI_HEIGHT, IMG_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      pixel_in,
  input  logic                  in_ready,
  input  logic                  frame_start,
  output logic [N_ROI*XW-1:0]   centroid_x,
  output logic [N_ROI-1:0]      band_valid,
  output logic signed [XW:0]    heading,
  output logic                  heading_valid,
  output logic                  line_lost,
  output logic                  out_ready
);

  localparam int YW  = $clog2(IMG_H);
  localparam int BIW = (N_ROI > 1) ? $clog2(N_ROI) : 1;
  localparam int LW  = $clog2(LOST_FRAMES + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [LW-1:0] LOST_MAX = LW'(LOST_FRAMES);

  state_t state, state_nxt;

  logic [XW-1:0]       x_cnt, cur_x;
  logic [YW-1:0]       y_cnt, cur_y;
  logic                abort;
  logic                in_band, band_last, hit, close, div_go;
  logic [BIW-1:0]      band_idx, div_band;
  logic [SW-1:0]       sum_acc, sum_tot;
  logic [CW-1:0]       cnt_acc, cnt_tot;
  logic                div_done, div_wr;
  logic [XW-1:0]       div_q;
  logic [N_ROI*XW-1:0] cent_nxt;
  logic [N_ROI-1:0]    valid_nxt;
  logic [LW-1:0]       lost_cnt;

  // A frame_start pulse relabels its own pixel as (0,0); anything short of a wrapped counter is an abort
  assign cur_x = frame_start ? '0 : x_cnt;
  assign cur_y = frame_start ? '0 : y_cnt;
  assign abort = frame_start && ((x_cnt != '0) || (y_cnt != '0));

  always_comb begin
    in_band   = 1'b0;
    band_last = 1'b0;
    band_idx  = '0;
    for (int k = 0; k < N_ROI; k++) begin
      if (int'(cur_y) >= IMG_H - (k + 1) * ROI_HEIGHT && int'(cur_y) < IMG_H - k * ROI_HEIGHT) begin
        in_band   = 1'b1;
        band_idx  = BIW'(k);
        band_last = (cur_x == X_LAST) && (int'(cur_y) == IMG_H - k * ROI_HEIGHT - 1);
      end
    end
  end

  assign hit     = in_ready && in_band && (int'(pixel_in) >= THRESHOLD);
  assign close   = in_ready && in_band && band_last;
  assign sum_tot = (abort ? SW'(0) : sum_acc) + (hit ? SW'(cur_x) : SW'(0));
  assign cnt_tot = (abort ? CW'(0) : cnt_acc) + CW'(hit);
  assign div_go  = close && (int'(cnt_tot) >= MIN_COUNT);
  assign div_wr  = div_done && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_ready) begin
      x_cnt <= (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
      if (cur_x == X_LAST) y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      else                 y_cnt <= cur_y;
    end else if (frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || close) begin
      sum_acc <= '0;
      cnt_acc <= '0;
    end else begin
      sum_acc <= sum_tot;
      cnt_acc <= cnt_tot;
    end
    if (rst)         div_band <= '0;
    else if (div_go) div_band <= band_idx;
  end

  seq_divider #(.NW(SW), .DW(CW), .QW(XW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go),
    .abort    (abort),
    .dividend (sum_tot),
    .divisor  (cnt_tot),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    cent_nxt  = centroid_x;
    valid_nxt = band_valid;
    if (div_wr) begin
      cent_nxt[div_band*XW +: XW] = div_q;
      valid_nxt[div_band]         = 1'b1;
    end
    if (close && !div_go) valid_nxt[band_idx] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_ready) state_nxt = ACCUM;
      ACCUM:   if (close) state_nxt = div_go ? DIVIDE : ((band_idx == '0) ? PUBLISH : ACCUM);
      DIVIDE:  if (div_wr) state_nxt = (div_band == '0) ? PUBLISH : ACCUM;
      PUBLISH: state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame summaries load on entry to PUBLISH so they are stable for the whole out_ready pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      centroid_x    <= '0;
      band_valid    <= '0;
      heading       <= '0;
      heading_valid <= 1'b0;
      lost_cnt      <= '0;
    end else begin
      centroid_x <= cent_nxt;
      band_valid <= valid_nxt;
      if (state_nxt == PUBLISH && state != PUBLISH) begin
        heading       <= $signed({1'b0, cent_nxt[(N_ROI-1)*XW +: XW]}) - $signed({1'b0, cent_nxt[0 +: XW]});
        heading_valid <= valid_nxt[0] && valid_nxt[N_ROI-1];
        if (valid_nxt[0])              lost_cnt <= '0;
        else if (lost_cnt != LOST_MAX) lost_cnt <= lost_cnt + LW'(1);
      end
    end
  end

  assign line_lost = (lost_cnt == LOST_MAX);
  assign out_ready = (state == PUBLISH);

endmodule

// File: tb/tb_multi_roi_centroid.sv
// Directed frames on a reduced 64x48 image (4 bands of 8 rows, XW=6) with hand-computed centroids.
module tb_multi_roi_centroid;

  localparam int IMG_W = 64;
  localparam int IMG_H = 48;
  localparam int XW    = 6;
  localparam int DIV_LAT = XW + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         pixel_in = '0;
  logic               in_ready = 1'b0;
  logic               frame_start = 1'b0;
  logic [4*XW-1:0]    centroid_x;
  logic [3:0]         band_valid;
  logic signed [XW:0] heading;
  logic               heading_valid;
  logic               line_lost;
  logic               out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  multi_roi_centroid #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(4), .N_ROI(4), .ROI_HEIGHT(8),
    .THRESHOLD(2), .MIN_COUNT(8), .LOST_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .frame_start(frame_start),
    .centroid_x(centroid_x), .band_valid(band_valid), .heading(heading),
    .heading_valid(heading_valid), .line_lost(line_lost), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Band rows: band3 16..23, band2 24..31, band1 32..39, band0 40..47
  function automatic logic [3:0] pix(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 30 && x <= 34) ? 4'd15 : 4'd0;
      2: return ((y >= 40 && x == 10) || (y >= 16 && y <= 23 && x == 50)) ? 4'd15 : 4'd0;
      3: if (y >= 40) return (y == 40 && x < 7) ? 4'd15 : 4'd1;
         else         return (x >= 30 && x <= 34) ? 4'd15 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  function automatic int field(input int k);
    return int'((centroid_x >> (k * XW)) & 24'h3F);
  endfunction

  task automatic send_frame(input int mode, input int rows, output int seen);
    seen = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        pixel_in    = pix(mode, x, y);
        in_ready    = 1'b1;
        frame_start = (x == 0 && y == 0);
        @(posedge clk); #1;
        if (out_ready === 1'b1) seen++;
      end
    end
    in_ready = 1'b0; frame_start = 1'b0; pixel_in = '0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (out_ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_ready !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (centroid_x !== '0) $display("FAIL reset_centroid: got %h want 0", centroid_x); else pass_cnt++;
    total_cnt++; if (band_valid !== 4'b0) $display("FAIL reset_band_valid: got %b want 0000", band_valid); else pass_cnt++;
    total_cnt++; if (heading !== '0 || heading_valid !== 1'b0) $display("FAIL reset_heading: got %0d/%b want 0/0", heading, heading_valid); else pass_cnt++;
    total_cnt++; if (line_lost !== 1'b0 || out_ready !== 1'b0) $display("FAIL reset_flags: got lost=%b rdy=%b want 0/0", line_lost, out_ready); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_centered;
    int seen, lat;
    send_frame(1, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (lat != DIV_LAT) $display("FAIL centered_latency: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
    total_cnt++; if (centroid_x !== {4{6'd32}}) $display("FAIL centered_centroids: got %h want %h", centroid_x, {4{6'd32}}); else pass_cnt++;
    total_cnt++; if (band_valid !== 4'b1111) $display("FAIL centered_valid: got %b want 1111", band_valid); else pass_cnt++;
    total_cnt++; if (heading !== 7'sd0 || heading_valid !== 1'b1) $display("FAIL centered_heading: got %0d/%b want 0/1", heading, heading_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_ready !== 1'b0) $display("FAIL centered_pulse: got %b want 0", out_ready); else pass_cnt++;
  endtask

  task automatic test_heading;
    int seen, lat;
    send_frame(2, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (lat != DIV_LAT) $display("FAIL heading_latency: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
    total_cnt++; if (heading !== 7'sd40 || heading_valid !== 1'b1) $display("FAIL heading_value: got %0d/%b want 40/1", heading, heading_valid); else pass_cnt++;
    total_cnt++; if (band_valid !== 4'b1001) $display("FAIL heading_valid_bits: got %b want 1001", band_valid); else pass_cnt++;
    total_cnt++; if (field(0) != 10 || field(1) != 32 || field(2) != 32 || field(3) != 50)
      $display("FAIL heading_fields: got %0d,%0d,%0d,%0d want 10,32,32,50", field(0), field(1), field(2), field(3)); else pass_cnt++;
  endtask

  task automatic test_min_count;
    int seen, lat;
    send_frame(3, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (lat != 1) $display("FAIL mincount_latency: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (band_valid !== 4'b1110) $display("FAIL mincount_valid: got %b want 1110", band_valid); else pass_cnt++;
    total_cnt++; if (field(0) != 10) $display("FAIL mincount_field0_held: got %0d want 10", field(0)); else pass_cnt++;
    total_cnt++; if (heading !== 7'sd22 || heading_valid !== 1'b0) $display("FAIL mincount_heading: got %0d/%b want 22/0", heading, heading_valid); else pass_cnt++;
  endtask

  task automatic test_line_lost;
    int seen, lat;
    logic exp_lost;
    send_frame(1, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (line_lost !== 1'b0 || lat != DIV_LAT) $display("FAIL lost_prime: got lost=%b lat=%0d want 0/%0d", line_lost, lat, DIV_LAT); else pass_cnt++;
    for (int f = 1; f <= 3; f++) begin
      send_frame(0, IMG_H, seen);
      wait_ready(lat);
      exp_lost = (f == 3);
      total_cnt++; if (lat != 1 || band_valid !== 4'b0000) $display("FAIL lost_empty_frame%0d: got lat=%0d valid=%b want 1/0000", f, lat, band_valid); else pass_cnt++;
      total_cnt++; if (line_lost !== exp_lost) $display("FAIL lost_flag_frame%0d: got %b want %b", f, line_lost, exp_lost); else pass_cnt++;
    end
    send_frame(1, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (line_lost !== 1'b0 || band_valid !== 4'b1111) $display("FAIL lost_recover: got lost=%b valid=%b want 0/1111", line_lost, band_valid); else pass_cnt++;
  endtask

  task automatic test_abort;
    int seen, lat, idle_rdy;
    send_frame(1, 30, seen);
    idle_rdy = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_ready === 1'b1) idle_rdy++;
    end
    total_cnt++; if (seen + idle_rdy != 0) $display("FAIL abort_no_ready: got %0d pulses want 0", seen + idle_rdy); else pass_cnt++;
    send_frame(2, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (seen != 0 || lat != DIV_LAT) $display("FAIL abort_next_timing: got seen=%0d lat=%0d want 0/%0d", seen, lat, DIV_LAT); else pass_cnt++;
    total_cnt++; if (heading !== 7'sd40 || band_valid !== 4'b1001 || field(0) != 10 || field(3) != 50)
      $display("FAIL abort_next_values: got hd=%0d valid=%b f0=%0d f3=%0d want 40/1001/10/50", heading, band_valid, field(0), field(3)); else pass_cnt++;
  endtask

  task automatic test_reset_in_divide;
    int seen, lat, rdy;
    send_frame(1, IMG_H, seen);
    repeat (2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (centroid_x !== '0 || band_valid !== 4'b0 || heading !== '0 || heading_valid !== 1'b0 || line_lost !== 1'b0 || out_ready !== 1'b0)
      $display("FAIL rstdiv_outputs: got c=%h v=%b hd=%0d hv=%b lost=%b rdy=%b want all 0", centroid_x, band_valid, heading, heading_valid, line_lost, out_ready); else pass_cnt++;
    rst = 1'b0;
    rdy = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_ready === 1'b1) rdy++;
    end
    total_cnt++; if (rdy != 0) $display("FAIL rstdiv_no_ready: got %0d pulses want 0", rdy); else pass_cnt++;
    send_frame(1, IMG_H, seen);
    wait_ready(lat);
    total_cnt++; if (lat != DIV_LAT || centroid_x !== {4{6'd32}} || band_valid !== 4'b1111)
      $display("FAIL rstdiv_recover: got lat=%0d c=%h v=%b want %0d/%h/1111", lat, centroid_x, band_valid, DIV_LAT, {4{6'd32}}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_centered();
    test_heading();
    test_min_count();
    test_line_lost();
    test_abort();
    test_reset_in_divide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multi_roi_centroid.md
MULTI_ROI_CENTROID -- requirements
Module: multi_roi_centroid

Interface
REQ-001 Parameter IMG_W, default 640: active pixels per line.
REQ-002 Parameter IMG_H, default 480: active lines per frame.
REQ-003 Parameter PIX_W, default 4: width of the input grey/edge pixel.
REQ-004 Parameter N_ROI, default 4: number of stacked horizontal bands; range 1..8.
REQ-005 Parameter ROI_HEIGHT, default 32: lines per band; N_ROI*ROI_HEIGHT SHALL be <= IMG_H.
REQ-006 Parameter THRESHOLD, default 2: minimum pixel value counted as an edge.
REQ-007 Parameter MIN_COUNT, default 8, minimum 1: edge pixels a band needs to be valid.
REQ-008 Parameter LOST_FRAMES, default 3: consecutive frames with band 0 invalid before line_lost asserts.
REQ-009 clk  in  1  single clock for all logic.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 pixel_in  in  PIX_W  raster-order pixel, qualified by in_ready.
REQ-012 in_ready  in  1  pixel_in valid this cycle.
REQ-013 frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-014 centroid_x  out  N_ROI*XW  packed per-band centroid, XW=$clog2(IMG_W); band k in bits [k*XW +: XW].
REQ-015 band_valid  out  N_ROI  per-band validity of the latest frame.
REQ-016 heading  out  XW+1  signed centroid[N_ROI-1] - centroid[0].
REQ-017 heading_valid  out  1  band_valid[0] and band_valid[N_ROI-1] both set.
REQ-018 line_lost  out  1  band 0 invalid for LOST_FRAMES consecutive frames.
REQ-019 out_ready  out  1  one-cycle pulse: all outputs updated for a completed frame.

Function
REQ-020 x/y counters SHALL advance on in_ready; x wraps at IMG_W-1, incrementing y; y wraps at IMG_H-1.
REQ-021 frame_start with in_ready SHALL treat that pixel as (0,0); without in_ready, the next pixel is (0,0).
REQ-022 Band k SHALL cover rows [IMG_H-(k+1)*ROI_HEIGHT, IMG_H-k*ROI_HEIGHT); band 0 is the bottom band.
REQ-023 Pixels in a band with pixel_in >= THRESHOLD SHALL add x to sum and 1 to count. Other pixels and pixels outside all bands SHALL be ignored.
REQ-024 Widths: CW=$clog2(ROI_HEIGHT*IMG_W+1) for count and SW=XW+CW for sum; no overflow is possible.
REQ-025 On the last pixel of a band, sum/count SHALL be latched and the accumulators cleared in the same cycle.
REQ-026 One shared sequential divider SHALL compute floor(sum/count) in XW+2 cycles (1 load, XW iterate, 1 write).
REQ-027 If count < MIN_COUNT, no divide SHALL start; band_valid[k]<=0 and centroid field k holds its previous value.
REQ-028 Otherwise the quotient SHALL be written to field k and band_valid[k]<=1.
REQ-029 Control FSM states: IDLE, ACCUM, DIVIDE, PUBLISH. IDLE->ACCUM on first pixel after rst. ACCUM->DIVIDE at a valid band close. DIVIDE->ACCUM when the quotient is written. ACCUM or DIVIDE->PUBLISH after band 0 is resolved. PUBLISH->ACCUM after one cycle.
REQ-030 out_ready SHALL pulse in PUBLISH, XW+2 cycles after the final frame pixel if band 0 divides, else 1 cycle after.
REQ-031 heading and heading_valid SHALL update in PUBLISH only.
REQ-032 A lost counter, saturating at LOST_FRAMES, SHALL increment in PUBLISH when band 0 is invalid and clear when it is valid; line_lost = (counter == LOST_FRAMES).
REQ-033 frame_start mid-frame SHALL discard the accumulators and any in-flight divide, and SHALL suppress out_ready for the aborted frame.
REQ-034 Pixels arriving during DIVIDE SHALL be accumulated normally; the divider is always free before the next band closes.

Reset
REQ-035 rst SHALL clear the counters, accumulators, divider, lost counter and FSM (to IDLE).
REQ-036 Output reset values: centroid_x=0, band_valid=0, heading=0, heading_valid=0, line_lost=0, out_ready=0.
REQ-037 rst SHALL take priority over frame_start and in_ready in the same cycle.

Structure
REQ-038 Package centroid_pkg SHALL hold the FSM state enum and the XW/CW/SW width helper functions.
REQ-039 The divider SHALL be a sub-module seq_divider (restoring, start/done handshake, parametrised widths).

Verification (IMG_W=640, IMG_H=480, N_ROI=4, ROI_HEIGHT=32, THRESHOLD=2, MIN_COUNT=8, LOST_FRAMES=3)
REQ-040 Value 15 at columns 318..322 on every row -> all centroids 320, band_valid=4'b1111, heading=0, out_ready 12 cycles after the last pixel.
REQ-041 Line at x=100 in band 0 and x=200 in band 3 -> heading=+100, heading_valid=1.
REQ-042 Three all-zero frames -> band_valid=0, line_lost rises at the third out_ready; one valid frame then clears it.
REQ-043 Band 0 with 7 pixels of value 15 plus many of value 1 -> band_valid[0]=0, centroid field 0 unchanged.
REQ-044 frame_start at row 300 -> no out_ready for that frame; the next full frame reports correctly.
REQ-045 rst asserted during DIVIDE -> all outputs 0 next cycle, no out_ready until a full frame completes.
